// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame scheduler: FSM states and fixed frame fields.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_ID   = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [3:0] ID_NIBBLE     = 4'h0;

endpackage

// File: rtl/uart_frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one above last_grant and wraps upward.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          w_found;
  logic [IW-1:0] w_c;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_c     = '0;
    for (int k = 1; k <= N; k++) begin
      w_c = IW'((int'(last_grant) + k) % N);
      if (!w_found && req[w_c]) begin
        w_found  = 1'b1;
        grant[w_c] = 1'b1;
        idx      = w_c;
      end
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Round-robin scheduler that frames requester samples into the UART TX FIFO.
// Define UART_FRAME_CHKSUM_EN to append a two's-complement checksum byte.
module uart_frame_sched
  import uart_frame_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter int         DATA_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_BYTES*8-1:0] req_data,
  output logic [NUM_REQ-1:0]              ack,
  input  logic                            tx_full,
  output logic                            tx_en,
  output logic [7:0]                      tx_data,
  output logic                            busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = DATA_BYTES * 8;

  state_e              r_state, w_next;
  logic [IW-1:0]       r_last, r_idx, w_idx;
  logic [NUM_REQ-1:0]  w_grant;
  logic [PW-1:0]       r_shift;
  logic [2:0]          r_cnt;
  logic [PW-1:0]       w_pay [NUM_REQ];
  logic                w_any, w_last_byte;
  logic [7:0]          w_id_byte;
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]          r_chk;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pay
    assign w_pay[g] = req_data[g*PW +: PW];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req),
    .last_grant (r_last),
    .grant      (w_grant),
    .idx        (w_idx)
  );

  assign w_any       = |req;
  assign w_id_byte   = {ID_NIBBLE, 4'(r_idx)};
  assign w_last_byte = (r_cnt == 3'(DATA_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next = ST_SYNC;
      ST_SYNC: if (tx_en) w_next = ST_ID;
      ST_ID:   if (tx_en) w_next = ST_DATA;
      ST_DATA: if (tx_en && w_last_byte) begin
`ifdef UART_FRAME_CHKSUM_EN
        w_next = ST_CHK;
`else
        w_next = ST_IDLE;
`endif
      end
`ifdef UART_FRAME_CHKSUM_EN
      ST_CHK:  if (tx_en) w_next = ST_IDLE;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Byte writes are gated only by tx_full, so a stall simply holds the current byte.
  always_comb begin
    ack     = '0;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    busy    = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: ack = w_grant;
      ST_SYNC: begin tx_en = !tx_full; tx_data = SYNC_BYTE; end
      ST_ID:   begin tx_en = !tx_full; tx_data = w_id_byte; end
      ST_DATA: begin tx_en = !tx_full; tx_data = r_shift[PW-1 -: 8]; end
`ifdef UART_FRAME_CHKSUM_EN
      ST_CHK:  begin tx_en = !tx_full; tx_data = ~r_chk + 8'd1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= IW'(NUM_REQ - 1);
      r_idx   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
`ifdef UART_FRAME_CHKSUM_EN
      r_chk   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
`ifdef UART_FRAME_CHKSUM_EN
          r_chk <= '0;
`endif
          if (w_any) begin
            r_shift <= w_pay[w_idx];
            r_idx   <= w_idx;
            r_last  <= w_idx;
          end
        end
`ifdef UART_FRAME_CHKSUM_EN
        ST_ID: if (tx_en) r_chk <= r_chk + w_id_byte;
`endif
        ST_DATA: if (tx_en) begin
          r_shift <= r_shift << 8;
          r_cnt   <= w_last_byte ? 3'd0 : r_cnt + 3'd1;
`ifdef UART_FRAME_CHKSUM_EN
          r_chk   <= r_chk + r_shift[PW-1 -: 8];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed per-cycle vector table for uart_frame_sched plus a fairness sequence.
module tb_uart_frame_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  ack;
  logic        tx_full;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef UART_FRAME_CHKSUM_EN
  localparam int FRAME = 6;
`else
  localparam int FRAME = 5;
`endif

  // r3=DEAD r2=1234 r1=BEEF r0=0102; D2 replaces it after ack to show it is not resampled
  localparam logic [63:0] D  = 64'hDEAD_1234_BEEF_0102;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [63:0] data;
    logic        full;
    logic [3:0]  ack;
    logic        en;
    logic [7:0]  txd;
    logic        busy;
  } vec_t;

  vec_t tbl [64];
  int   n = 0;

  uart_frame_sched #(.NUM_REQ(4), .DATA_BYTES(2), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_full  (tx_full),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] rq, input logic [63:0] d, input logic f,
                     input logic [3:0] a, input logic e, input logic [7:0] t, input logic b);
    tbl[n].rst = r; tbl[n].req = rq; tbl[n].data = d; tbl[n].full = f;
    tbl[n].ack = a; tbl[n].en = e; tbl[n].txd = t; tbl[n].busy = b;
    n++;
  endtask

  initial begin
    int got, last_c;

    // single request from requester 2, after reset
    add(0, 4'b0000, D,  0, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0100, D,  0, 4'b0100, 0, 8'h00, 0);
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'hA5, 1);
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'h02, 1);
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'h12, 1);
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'h34, 1);
`ifdef UART_FRAME_CHKSUM_EN
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'hB8, 1);
`endif
    add(0, 4'b0000, D,  0, 4'b0000, 0, 8'h00, 0);
    // backpressure on requester 1: five stalled cycles on ID, one on the second payload byte
    add(0, 4'b0010, D,  0, 4'b0010, 0, 8'h00, 0);
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'hA5, 1);
    for (int i = 0; i < 5; i++) add(0, 4'b0000, D2, 1, 4'b0000, 0, 8'h01, 1);
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'h01, 1);
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'hBE, 1);
    add(0, 4'b0000, D2, 1, 4'b0000, 0, 8'hEF, 1);
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'hEF, 1);
`ifdef UART_FRAME_CHKSUM_EN
    add(0, 4'b0000, D2, 0, 4'b0000, 1, 8'h52, 1);
`endif
    add(0, 4'b0000, D,  0, 4'b0000, 0, 8'h00, 0);
    // reset during the first payload byte of requester 2's frame
    add(0, 4'b0100, D,  0, 4'b0100, 0, 8'h00, 0);
    add(0, 4'b0000, D,  0, 4'b0000, 1, 8'hA5, 1);
    add(0, 4'b0000, D,  0, 4'b0000, 1, 8'h02, 1);
    add(1, 4'b0000, D,  0, 4'b0000, 1, 8'h12, 1);
    add(0, 4'b0000, D,  0, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b1001, D,  0, 4'b0001, 0, 8'h00, 0);
    // requester 1 rises mid-frame and waits for IDLE
    add(0, 4'b0010, D,  0, 4'b0000, 1, 8'hA5, 1);
    add(0, 4'b0010, D,  0, 4'b0000, 1, 8'h00, 1);
    add(0, 4'b0010, D,  0, 4'b0000, 1, 8'h01, 1);
    add(0, 4'b0010, D,  0, 4'b0000, 1, 8'h02, 1);
`ifdef UART_FRAME_CHKSUM_EN
    add(0, 4'b0010, D,  0, 4'b0000, 1, 8'hFD, 1);
`endif
    add(0, 4'b0010, D,  0, 4'b0010, 0, 8'h00, 0);
    add(0, 4'b0000, D,  0, 4'b0000, 1, 8'hA5, 1);
    add(0, 4'b0000, D,  0, 4'b0000, 1, 8'h01, 1);
    add(0, 4'b0000, D,  0, 4'b0000, 1, 8'hBE, 1);
    add(0, 4'b0000, D,  0, 4'b0000, 1, 8'hEF, 1);
`ifdef UART_FRAME_CHKSUM_EN
    add(0, 4'b0000, D,  0, 4'b0000, 1, 8'h52, 1);
`endif
    add(0, 4'b0000, D,  0, 4'b0000, 0, 8'h00, 0);

    rst = 1'b1; req = '0; req_data = D; tx_full = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; req_data = tbl[i].data; tx_full = tbl[i].full;
      #1;
      checks++;
      if (ack !== tbl[i].ack || tx_en !== tbl[i].en || tx_data !== tbl[i].txd || busy !== tbl[i].busy) begin
        errors++;
        $display("FAIL row%0d: ack=%b tx_en=%b tx_data=%h busy=%b, expected ack=%b tx_en=%b tx_data=%h busy=%b",
                 i, ack, tx_en, tx_data, busy, tbl[i].ack, tbl[i].en, tbl[i].txd, tbl[i].busy);
      end
    end

    // fairness: all requesters held high from reset
    @(negedge clk); rst = 1'b1; req = '0;
    @(negedge clk); rst = 1'b0; req = 4'hF;
    got = 0; last_c = 0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (ack != 4'b0000) begin
        checks++;
        if (ack !== 4'(1 << (got % 4))) begin
          errors++;
          $display("FAIL fair_order%0d: ack=%b expected %b", got, ack, 4'(1 << (got % 4)));
        end
        if (got > 0) begin
          checks++;
          if (c - last_c != FRAME) begin
            errors++;
            $display("FAIL fair_gap%0d: spacing=%0d expected %0d", got, c - last_c, FRAME);
          end
        end
        last_c = c;
        got++;
      end else if (got > 0 && c - last_c == 2) begin
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'((got - 1) % 4)) begin
          errors++;
          $display("FAIL fair_id%0d: tx_en=%b tx_data=%h expected 1 %h", got - 1, tx_en, tx_data, 8'((got - 1) % 4));
        end
      end
    end
    checks++;
    if (got < 8) begin
      errors++;
      $display("FAIL fair_count: grants=%0d expected 8", got);
    end
    @(negedge clk); req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
